// File: rtl/xor_sched_pkg.sv
// xor_sched_pkg
//   Shared definitions for the round-robin XOR scheduler:
//   - state_t        : output-slot state (IDLE = empty, HOLD = result held)
//   - DEF_*          : default parameter values for xor_sched
//   - DEF_CNT_MAX    : saturation value of the completed-operation counter
//                      at the default counter width
package xor_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/xor_sched_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Starting at index ptr and
//   walking upward (mod N), the first asserted req bit wins.
//   Ports:
//     req      in  N     request vector
//     ptr      in  ID_W  highest-priority index for this cycle
//     en       in  1     when low, no grant is issued
//     grant    out N     one-hot grant (all zero when nothing granted)
//     grant_id out ID_W  index of the winner (0 when nothing valid)
//     any      out 1     at least one request is valid
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    always_comb begin
        grant_id = '0;
        any      = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = idx;
            end
        end
    end

    // Decode the winning index; en gates every bit so a blocked slot
    // never shows a grant.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = en & any & (grant_id == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/xor_sched.sv
// xor_sched
//   Shares one registered XOR unit among N_REQ requesters. One request is
//   granted per cycle in round-robin order; its result a ^ b appears on the
//   tagged response port the following cycle and is held until accepted.
//   Ports:
//     clk        in   1             rising-edge clock
//     rst        in   1             synchronous active-high reset
//     req_valid  in   N_REQ         per-requester operand valid
//     req_ready  out  N_REQ         per-requester grant (one-hot or zero)
//     req_a      in   N_REQ*WIDTH   operand a, requester i at [i*WIDTH +: WIDTH]
//     req_b      in   N_REQ*WIDTH   operand b, same packing
//     rsp_valid  out  1             result valid
//     rsp_ready  in   1             consumer accepts result
//     rsp_c      out  WIDTH         a ^ b of the granted request
//     rsp_id     out  ID_W          index of the requester that produced rsp_c
//     ops_count  out  CNT_W         completed responses, saturating
//     busy       out  1             result held and not being accepted
module xor_sched
    import xor_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_c,
    output logic [ID_W-1:0]        rsp_id,
    output logic [CNT_W-1:0]       ops_count,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  rsp_c_reg, rsp_c_next;
    logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]  ops_reg, ops_next;

    logic              slot_free;
    logic              rsp_fire;
    logic              transfer;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  op_a [N_REQ];
    logic [WIDTH-1:0]  op_b [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register may be reloaded in the same cycle its current
    // contents are taken, which is what gives one op per cycle.
    assign rsp_fire  = (state_reg == HOLD) & rsp_ready;
    assign slot_free = (state_reg == IDLE) | rsp_ready;

    // rst gates the arbiter so nothing is granted (or lost) in a reset cycle.
    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_reg),
        .en       (slot_free & ~rst),
        .grant    (req_ready),
        .grant_id (grant_id),
        .any      (grant_any)
    );

    assign transfer = |(req_valid & req_ready);

    always_comb begin
        state_next  = state_reg;
        rsp_c_next  = rsp_c_reg;
        rsp_id_next = rsp_id_reg;
        ptr_next    = ptr_reg;
        ops_next    = ops_reg;

        if (rsp_fire && (ops_reg != CNT_MAX)) begin
            ops_next = ops_reg + 1'b1;
        end

        if (transfer) begin
            state_next  = HOLD;
            rsp_c_next  = op_a[grant_id] ^ op_b[grant_id];
            rsp_id_next = grant_id;
            ptr_next    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end else if (rsp_fire) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rsp_c_reg  <= '0;
            rsp_id_reg <= '0;
            ptr_reg    <= '0;
            ops_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rsp_c_reg  <= rsp_c_next;
            rsp_id_reg <= rsp_id_next;
            ptr_reg    <= ptr_next;
            ops_reg    <= ops_next;
        end
    end

    assign rsp_valid = (state_reg == HOLD);
    assign rsp_c     = rsp_c_reg;
    assign rsp_id    = rsp_id_reg;
    assign ops_count = ops_reg;
    assign busy      = (state_reg == HOLD) & ~rsp_ready;

endmodule
